// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the 16-bit register/ALU datapath.
// Optional macro CPU_SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module cpu_seq_ctrl #(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]       OP_LOAD  = 8'b10011001,
    parameter logic [7:0]       OP_STORE = 8'b11011010,
    parameter logic [7:0]       OP_NOP   = 8'b00010111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       mem_rdata,
    input  logic [15:0]       reg_a,
    input  logic [15:0]       reg_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic [15:0]       instruction,
    output logic              ren,
    output logic              load_mux,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef CPU_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_LOAD_WB
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              boundary;
    logic [7:0]        opcode;

    assign opcode = ir_q[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALT;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        boundary  = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = reg_b;
        mem_we    = 1'b0;
        ren       = 1'b0;
        load_mux  = 1'b0;
        halted    = 1'b0;

        case (state_q)
            S_HALT: begin
                halted = 1'b1;
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_LOAD) begin
                    mem_addr = reg_a[ADDR_W-1:0];
                    state_d  = S_LOAD_WB;
                end else if (opcode == OP_STORE) begin
                    mem_addr = reg_a[ADDR_W-1:0];
                    mem_we   = 1'b1;
                    boundary = 1'b1;
                end else if (opcode == OP_NOP) begin
                    boundary = 1'b1;
                end else begin
                    // ALU/CMP/unknown all write back; CMP suppression lives in the datapath
                    ren      = 1'b1;
                    boundary = 1'b1;
                end
            end
            S_LOAD_WB: begin
                mem_addr = reg_a[ADDR_W-1:0];
                ren      = 1'b1;
                load_mux = 1'b1;
                boundary = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (boundary) state_d = run ? S_FETCH : S_HALT;

        // Reset aborts any in-flight instruction before a strobe can commit
        if (reset) begin
            mem_we   = 1'b0;
            ren      = 1'b0;
            load_mux = 1'b0;
        end
    end

`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else if (boundary) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
`endif

    assign instruction = ir_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: random program/inputs against an instruction-phase reference model,
// plus a directed PC-wrap check on a second instance with RESET_PC = 16'hFFFF.
module tb_cpu_seq_ctrl;

    localparam logic [7:0] OP_LOAD  = 8'b10011001;
    localparam logic [7:0] OP_STORE = 8'b11011010;
    localparam logic [7:0] OP_NOP   = 8'b00010111;

    int tests_run = 0;
    int tests_failed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_r, run_r;
    logic [15:0] reg_a_r, reg_b_r;
    logic [15:0] mem_rdata;
    logic [15:0] mem_addr, mem_wdata, instruction, pc;
    logic        mem_we, ren, load_mux, halted;
`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    cpu_seq_ctrl #(.ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .reset(reset_r), .run(run_r), .mem_rdata(mem_rdata),
        .reg_a(reg_a_r), .reg_b(reg_b_r), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .instruction(instruction), .ren(ren), .load_mux(load_mux),
        .pc(pc), .halted(halted)
`ifdef CPU_SEQ_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    logic        w_reset, w_run;
    logic [15:0] w_reg_a, w_reg_b, w_rdata;
    logic [15:0] w_addr, w_wdata, w_instr, w_pc;
    logic        w_we, w_ren, w_lm, w_halted;
`ifdef CPU_SEQ_RETIRE_CNT_EN
    logic [31:0] w_retired;
`endif

    cpu_seq_ctrl #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .reset(w_reset), .run(w_run), .mem_rdata(w_rdata),
        .reg_a(w_reg_a), .reg_b(w_reg_b), .mem_addr(w_addr), .mem_wdata(w_wdata),
        .mem_we(w_we), .instruction(w_instr), .ren(w_ren), .load_mux(w_lm),
        .pc(w_pc), .halted(w_halted)
`ifdef CPU_SEQ_RETIRE_CNT_EN
        , .retired(w_retired)
`endif
    );

    // Memories: synchronous single-port for the main instance; all-NOP for the wrap instance.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        w_rdata   <= {OP_NOP, w_addr[7:0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: position within the current instruction (0=fetch,1=decode,2=exec,3=load wb)
    bit          m_known = 1'b0;
    bit          m_halted;
    int          m_k;
    logic [15:0] m_pc, m_ir;
    logic [31:0] m_ret;

    task automatic step(input bit rst, input bit rn, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] e_addr;
        bit          chk_addr;
        bit          e_we, e_ren, e_lm, boundary;
        logic [7:0]  op;
        @(negedge clk);
        reset_r = rst; run_r = rn; reg_a_r = a; reg_b_r = b;
        #1;
        op = m_ir[15:8];
        e_addr = m_pc; chk_addr = 1'b1;
        e_we = 1'b0; e_ren = 1'b0; e_lm = 1'b0;
        if (!m_halted && m_k == 2) begin
            if (op == OP_LOAD) e_addr = a;
            else if (op == OP_STORE) begin e_addr = a; e_we = 1'b1; end
            else begin chk_addr = 1'b0; e_ren = (op != OP_NOP); end
        end else if (!m_halted && m_k == 3) begin
            e_addr = a; e_ren = 1'b1; e_lm = 1'b1;
        end
        if (rst) begin
            check("rst_we", 32'(mem_we), 32'd0);
            check("rst_ren", 32'(ren), 32'd0);
            check("rst_load_mux", 32'(load_mux), 32'd0);
        end else if (m_known) begin
            check("halted", 32'(halted), 32'(m_halted));
            check("pc", 32'(pc), 32'(m_pc));
            check("instruction", 32'(instruction), 32'(m_ir));
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("ren", 32'(ren), 32'(e_ren));
            check("load_mux", 32'(load_mux), 32'(e_lm));
            check("mem_wdata", 32'(mem_wdata), 32'(b));
            if (chk_addr) check("mem_addr", 32'(mem_addr), 32'(e_addr));
`ifdef CPU_SEQ_RETIRE_CNT_EN
            check("retired", retired, m_ret);
`endif
        end
        // advance model across the coming edge
        boundary = 1'b0;
        if (rst) begin
            m_known = 1'b1; m_halted = 1'b1; m_k = 0;
            m_pc = 16'h0000; m_ir = 16'h0000; m_ret = 32'd0;
        end else if (m_known) begin
            if (m_halted) begin
                if (rn) begin m_halted = 1'b0; m_k = 0; end
            end else if (m_k == 0) m_k = 1;
            else if (m_k == 1) begin
                m_ir = ref_mem[m_pc]; m_pc = m_pc + 16'd1; m_k = 2;
            end else if (m_k == 2) begin
                if (op == OP_STORE) ref_mem[a] = b;
                if (op == OP_LOAD) m_k = 3; else boundary = 1'b1;
            end else boundary = 1'b1;
            if (boundary) begin
                m_ret = m_ret + 32'd1;
                if (rn) m_k = 0; else m_halted = 1'b1;
            end
        end
    endtask

    task automatic wstep(input bit rst, input bit rn);
        @(negedge clk);
        w_reset = rst; w_run = rn;
        w_reg_a = 16'($urandom); w_reg_b = 16'($urandom);
        #1;
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  opc;
        bit          rst, rn, inj;
        reset_r = 1'b1; run_r = 1'b1; reg_a_r = 16'h0; reg_b_r = 16'h0;
        w_reset = 1'b1; w_run = 1'b1; w_reg_a = 16'h0; w_reg_b = 16'h0;

        for (int i = 0; i < 65536; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    opc = OP_LOAD;
                2, 3:    opc = OP_STORE;
                4:       opc = OP_NOP;
                default: opc = 8'($urandom);
            endcase
            v = {opc, 8'($urandom)};
            mem[i] = v; ref_mem[i] = v;
        end
        mem[0] = 16'h0012; ref_mem[0] = 16'h0012;
        mem[1] = 16'h9953; ref_mem[1] = 16'h9953;
        mem[2] = 16'hDA21; ref_mem[2] = 16'hDA21;
        mem[16'h40] = 16'hBEEF; ref_mem[16'h40] = 16'hBEEF;

        // PC-wrap instance: NOP at 0xFFFF
        wstep(1'b1, 1'b1);
        wstep(1'b1, 1'b1);
        check("wrap_rst_halted", 32'(w_halted), 32'd1);
        check("wrap_rst_pc", 32'(w_pc), 32'hFFFF);
        check("wrap_rst_instr", 32'(w_instr), 32'd0);
        check("wrap_rst_ren", 32'(w_ren), 32'd0);
        wstep(1'b0, 1'b1);
        check("wrap_halt_cycle", 32'(w_halted), 32'd1);
        wstep(1'b0, 1'b1);
        check("wrap_fetch_halted", 32'(w_halted), 32'd0);
        check("wrap_fetch_addr", 32'(w_addr), 32'hFFFF);
        wstep(1'b0, 1'b1);
        check("wrap_decode_pc", 32'(w_pc), 32'hFFFF);
        wstep(1'b0, 1'b1);
        check("wrap_exec_pc", 32'(w_pc), 32'h0000);
        check("wrap_exec_instr", 32'(w_instr), {16'h0, OP_NOP, 8'hFF});
        check("wrap_exec_ren", 32'(w_ren), 32'd0);
        check("wrap_exec_we", 32'(w_we), 32'd0);
        check("wrap_exec_lm", 32'(w_lm), 32'd0);
        check("wrap_wdata", 32'(w_wdata), 32'(w_reg_b));
        wstep(1'b0, 1'b1);
        check("wrap_next_fetch_addr", 32'(w_addr), 32'h0000);
`ifdef CPU_SEQ_RETIRE_CNT_EN
        check("wrap_retired", w_retired, 32'd1);
`endif
        wstep(1'b1, 1'b0);

        // Main instance: reset held two cycles with run high
        step(1'b1, 1'b1, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 16'h0000, 16'h0000);
        // directed ALU, LOAD (reg_a=0x40), STORE (reg_a=0x10, reg_b=0x1234)
        for (int c = 0; c < 12; c++) begin
            if (m_ir == 16'h9953) step(1'b0, 1'b1, 16'h0040, 16'h5555);
            else if (m_ir == 16'hDA21) step(1'b0, 1'b1, 16'h0010, 16'h1234);
            else step(1'b0, 1'b1, 16'h0040, 16'h1234);
        end
        inj = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rn  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 199) == 0);
            if (!inj && !m_halted && m_k == 2 && m_ir[15:8] == OP_STORE) begin
                rst = 1'b1; inj = 1'b1;
            end
            step(rst, rn, ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom), 16'($urandom));
        end
        check("store_reset_injected", 32'(inj), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
